// File: rtl/seg_scan_controller_pkg.sv
// seg_pkg: definitions shared by the 7-segment scan controller files.
//   - SLOT_*       : refresh_sel value for each digit position (0 = ones, rightmost)
//   - ANODE_OFF    : active-low anode pattern with every digit dark
//   - scan_state_t : scan FSM states (GUARD = anodes dark, ON = digit lit)
//   - nibble_at    : selects one BCD digit out of the 16-bit digit word
//   - lz_blank     : leading-zero suppression test for one slot
package seg_pkg;

    localparam logic [1:0] SLOT_ONES      = 2'd0;
    localparam logic [1:0] SLOT_TENS      = 2'd1;
    localparam logic [1:0] SLOT_HUNDREDS  = 2'd2;
    localparam logic [1:0] SLOT_THOUSANDS = 2'd3;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef enum logic {
        GUARD = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // Digit word layout is {thousands, hundreds, tens, ones}.
    function automatic logic [3:0] nibble_at(input logic [15:0] digits, input logic [1:0] slot);
        return digits[{slot, 2'b00} +: 4];
    endfunction

    // A digit is a leading zero only if it and every more significant digit
    // are zero. The ones digit is always shown so "0" never goes fully dark.
    function automatic logic lz_blank(input logic [15:0] digits, input logic [1:0] slot);
        logic blank;
        case (slot)
            SLOT_THOUSANDS: blank = (digits[15:12] == 4'd0);
            SLOT_HUNDREDS:  blank = (digits[15:8] == 8'd0);
            SLOT_TENS:      blank = (digits[15:4] == 12'd0);
            default:        blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// seg_scan_controller_if: valid/ready load port for the four BCD digits.
//   load_valid  : producer has a new digit word
//   load_digits : {thousands, hundreds, tens, ones}, 4 bits each
//   load_ready  : controller can take a word (pending buffer empty)
// master = digit producer (counter/BCD logic), slave = scan controller.
interface seg_scan_controller_if;
    import seg_pkg::*;

    logic        load_valid;
    logic [15:0] load_digits;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_digits,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_digits,
        output load_ready
    );

endinterface

// File: rtl/seg_scan_controller_digit_buffer.sv
// seg_digit_buffer: double buffer between the digit producer and the scan.
//   clk, rst_n  : clock, synchronous active-low reset
//   commit      : 1 on the final cycle of a frame; moves pending -> active
//   load_if     : valid/ready load port (slave side)
//   active_next : value the active buffer takes at the coming edge, so the
//                 top can register digit outputs in step with a commit
module seg_digit_buffer (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         commit,
    seg_scan_controller_if.slave         load_if,
    output logic [15:0]                  active_next
);
    import seg_pkg::*;

    logic [15:0] pending_q, pending_d;
    logic [15:0] active_q, active_d;
    logic        pending_full_q, pending_full_d;
    logic        accept;

    assign load_if.load_ready = !pending_full_q;
    assign accept             = load_if.load_valid && !pending_full_q;
    assign active_next        = active_d;

    // Commit and accept never collide: accept needs the pending buffer empty
    // and a commit only happens when it is full. A load landing on the
    // commit cycle therefore waits a whole frame in pending (no bypass).
    always_comb begin
        pending_d      = pending_q;
        active_d       = active_q;
        pending_full_d = pending_full_q;
        if (commit && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end else if (accept) begin
            pending_d      = load_if.load_digits;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q      <= '0;
            active_q       <= '0;
            pending_full_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            active_q       <= active_d;
            pending_full_q <= pending_full_d;
        end
    end

endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: 4-digit 7-segment time-multiplexing scheduler.
//   clk, rst_n   : clock, synchronous active-low reset
//   enable       : 1 runs the scan, 0 freezes it with all anodes off
//   lz_en        : leading-zero blanking enable
//   load_if      : valid/ready digit load port (slave)
//   refresh_sel  : current slot, 0 = ones ... 3 = thousands
//   digit_value  : active-buffer nibble for the current slot
//   digit_blank  : current digit suppressed as a leading zero
//   anode_n      : active-low anode enables, bit i lit when refresh_sel == i
//   frame_done   : one-cycle pulse on the last cycle of slot 3
// Every slot is REFRESH_DIV cycles; its first BLANK_CYCLES cycles keep all
// anodes dark so the segment path can settle on the new digit (anti-ghosting).
module seg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 lz_en,
    seg_scan_controller_if.slave load_if,
    output logic [1:0]           refresh_sel,
    output logic [3:0]           digit_value,
    output logic                 digit_blank,
    output logic [3:0]           anode_n,
    output logic                 frame_done
);
    import seg_pkg::*;

    localparam int             PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  LAST      = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]  BLANK_LIM = PW'(BLANK_CYCLES);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sel_q, sel_d;
    scan_state_t   state_q, state_d;
    logic [3:0]    anode_n_q, anode_n_d;
    logic [3:0]    digit_value_q, digit_value_d;
    logic          digit_blank_q, digit_blank_d;
    logic          frame_done_q, frame_done_d;
    logic          wrap;
    logic          commit;
    logic [15:0]   active_next;

    seg_digit_buffer u_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit      (commit),
        .load_if     (load_if),
        .active_next (active_next)
    );

    // Prescaler and slot counter. Both simply hold while disabled, so
    // re-enabling resumes the interrupted slot where it left off.
    always_comb begin
        presc_d = presc_q;
        sel_d   = sel_q;
        wrap    = enable && (presc_q == LAST);
        if (enable) begin
            if (wrap) begin
                presc_d = '0;
                sel_d   = sel_q + 2'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        commit = wrap && (sel_q == SLOT_THOUSANDS);
    end

    // Scan FSM and output decode. Everything is computed from the values the
    // counters take at the coming edge, so the registered outputs line up
    // with the prescaler and the new digit appears exactly as its slot (and
    // its guard interval) begins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GUARD:   if (presc_d >= BLANK_LIM) state_d = ON;
            ON:      if (presc_d <  BLANK_LIM) state_d = GUARD;
            default: state_d = GUARD;
        endcase

        digit_value_d = nibble_at(active_next, sel_d);
        digit_blank_d = lz_en && lz_blank(active_next, sel_d);

        anode_n_d = ANODE_OFF;
        if (enable && (state_d == ON) && !digit_blank_d) begin
            anode_n_d = ~(4'b0001 << sel_d);
        end

        frame_done_d = enable && (presc_d == LAST) && (sel_d == SLOT_THOUSANDS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q       <= '0;
            sel_q         <= SLOT_ONES;
            state_q       <= GUARD;
            anode_n_q     <= ANODE_OFF;
            digit_value_q <= 4'd0;
            digit_blank_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            sel_q         <= sel_d;
            state_q       <= state_d;
            anode_n_q     <= anode_n_d;
            digit_value_q <= digit_value_d;
            digit_blank_q <= digit_blank_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign refresh_sel = sel_q;
    assign digit_value = digit_value_q;
    assign digit_blank = digit_blank_q;
    assign anode_n     = anode_n_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed self-checking bench for seg_scan_controller
// with REFRESH_DIV = 8 and BLANK_CYCLES = 2 (32-cycle frames).
module tb_seg_scan_controller;
    import seg_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       lz_en;
    logic [1:0] refresh_sel;
    logic [3:0] digit_value;
    logic       digit_blank;
    logic [3:0] anode_n;
    logic       frame_done;

    int errors = 0;
    int checks = 0;
    logic exp_full = 1'b0;

    seg_scan_controller_if load_if ();

    seg_scan_controller #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .lz_en       (lz_en),
        .load_if     (load_if),
        .refresh_sel (refresh_sel),
        .digit_value (digit_value),
        .digit_blank (digit_blank),
        .anode_n     (anode_n),
        .frame_done  (frame_done)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the scan never produces what the sequence waits on
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] digits);
        load_if.load_valid  = valid;
        load_if.load_digits = digits;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full frame starting at prescaler 0 / slot 0 and checks every
    // cycle. shown is the digit word the frame must display, mask holds the
    // slots expected to be blanked as leading zeros. Loads are started at
    // cycles la1/la2 (-1 = none) and held until the controller takes them.
    task automatic run_frame(input string name, input logic [15:0] shown, input logic [3:0] mask,
                             input int la1, input logic [15:0] lv1,
                             input int la2, input logic [15:0] lv2);
        for (int k = 0; k < 32; k++) begin
            int         s;
            int         p;
            logic [3:0] exp_an;
            logic       rdy;
            logic       model_acc;
            logic       model_commit;
            s = k / 8;
            p = k % 8;
            exp_an = ((p < 2) || mask[s]) ? 4'b1111 : ~(4'b0001 << s);
            checkOutput($sformatf("%s k=%0d refresh_sel", name, k), 16'(refresh_sel), 16'(s));
            checkOutput($sformatf("%s k=%0d anode_n", name, k), 16'(anode_n), 16'(exp_an));
            checkOutput($sformatf("%s k=%0d digit_value", name, k), 16'(digit_value), 16'(shown[s*4 +: 4]));
            checkOutput($sformatf("%s k=%0d digit_blank", name, k), 16'(digit_blank), 16'(mask[s]));
            checkOutput($sformatf("%s k=%0d frame_done", name, k), 16'(frame_done), 16'(k == 31));
            if (k == la1) applyStimulus(1'b1, lv1);
            if (k == la2) applyStimulus(1'b1, lv2);
            checkOutput($sformatf("%s k=%0d load_ready", name, k), 16'(load_if.load_ready), 16'(!exp_full));
            rdy          = load_if.load_ready;
            model_commit = (k == 31) && exp_full;
            model_acc    = load_if.load_valid && !exp_full;
            tick();
            if (model_commit) exp_full = 1'b0;
            else if (model_acc) exp_full = 1'b1;
            if (load_if.load_valid && rdy) load_if.load_valid = 1'b0;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        lz_en  = 1'b0;
        applyStimulus(1'b0, 16'h0000);

        // Reset held for three edges
        repeat (3) tick();
        checkOutput("reset anode_n", 16'(anode_n), 16'h000f);
        checkOutput("reset refresh_sel", 16'(refresh_sel), 16'h0000);
        checkOutput("reset digit_value", 16'(digit_value), 16'h0000);
        checkOutput("reset digit_blank", 16'(digit_blank), 16'h0000);
        checkOutput("reset frame_done", 16'(frame_done), 16'h0000);
        checkOutput("reset load_ready", 16'(load_if.load_ready), 16'h0001);
        rst_n = 1'b1;

        // Mid-frame load: current frame still 0000, next frame 1234
        run_frame("F0", 16'h0000, 4'b0000, 10, 16'h1234, -1, 16'h0000);
        // Back-to-back loads: 2222 waits for the 1111 commit
        run_frame("F1", 16'h1234, 4'b0000, 3, 16'h1111, 6, 16'h2222);
        run_frame("F2", 16'h1111, 4'b0000, -1, 16'h0000, -1, 16'h0000);
        // Load on the frame_done cycle: shown one frame later than usual
        run_frame("F3", 16'h2222, 4'b0000, 31, 16'h5678, -1, 16'h0000);
        run_frame("F4", 16'h2222, 4'b0000, -1, 16'h0000, -1, 16'h0000);
        // Leading-zero blanking
        lz_en = 1'b1;
        run_frame("F5", 16'h5678, 4'b0000, 2, 16'h0045, -1, 16'h0000);
        run_frame("F6", 16'h0045, 4'b1100, 1, 16'h0000, -1, 16'h0000);
        run_frame("F7", 16'h0000, 4'b1110, 5, 16'h8008, -1, 16'h0000);
        run_frame("F8", 16'h8008, 4'b0000, -1, 16'h0000, -1, 16'h0000);

        // Freeze at prescaler 5 of slot 0 for ten cycles
        lz_en = 1'b0;
        repeat (5) tick();
        checkOutput("pre-freeze anode_n", 16'(anode_n), 16'h000e);
        checkOutput("pre-freeze digit_value", 16'(digit_value), 16'h0008);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("frozen i=%0d anode_n", i), 16'(anode_n), 16'h000f);
            checkOutput($sformatf("frozen i=%0d refresh_sel", i), 16'(refresh_sel), 16'h0000);
            checkOutput($sformatf("frozen i=%0d frame_done", i), 16'(frame_done), 16'h0000);
        end
        enable = 1'b1;
        tick();
        checkOutput("resume p6 anode_n", 16'(anode_n), 16'h000e);
        checkOutput("resume p6 refresh_sel", 16'(refresh_sel), 16'h0000);
        tick();
        checkOutput("resume p7 anode_n", 16'(anode_n), 16'h000e);
        checkOutput("resume p7 refresh_sel", 16'(refresh_sel), 16'h0000);
        tick();
        checkOutput("resume next slot refresh_sel", 16'(refresh_sel), 16'h0001);
        checkOutput("resume next slot anode_n", 16'(anode_n), 16'h000f);
        checkOutput("resume next slot digit_value", 16'(digit_value), 16'h0000);

        // Reset mid-slot with the pending buffer full
        applyStimulus(1'b1, 16'h9999);
        tick();
        load_if.load_valid = 1'b0;
        checkOutput("pending full load_ready", 16'(load_if.load_ready), 16'h0000);
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("midreset anode_n", 16'(anode_n), 16'h000f);
        checkOutput("midreset refresh_sel", 16'(refresh_sel), 16'h0000);
        checkOutput("midreset digit_value", 16'(digit_value), 16'h0000);
        checkOutput("midreset digit_blank", 16'(digit_blank), 16'h0000);
        checkOutput("midreset frame_done", 16'(frame_done), 16'h0000);
        checkOutput("midreset load_ready", 16'(load_if.load_ready), 16'h0001);
        rst_n    = 1'b1;
        exp_full = 1'b0;
        // Discarded pending word must never reach the display
        run_frame("R0", 16'h0000, 4'b0000, -1, 16'h0000, -1, 16'h0000);
        run_frame("R1", 16'h0000, 4'b0000, -1, 16'h0000, -1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Time-multiplexing scheduler for the 4-digit 7-segment display. It owns the digit-select sequence (refresh_sel) and the active-low anode enables, and it inserts an anode-off guard interval at each digit switch to prevent ghosting. It double-buffers the four BCD digits behind a valid/ready load port, so a new value never tears mid-frame, and it applies optional leading-zero blanking. It sits between the counter/BCD logic and the existing digit-select mux and segment decoder.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz clock gives 1 kHz per digit, 250 Hz frame); must be >= BLANK_CYCLES+2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (0 disables the guard)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  synchronous reset, active-low
enable  in  1  1 runs the scan; 0 freezes the scan and turns all anodes off
lz_en  in  1  1 enables leading-zero blanking
load_valid  in  1  load request
load_digits  in  16  {thousands, hundreds, tens, ones}, 4 bits each; [3:0] is ones (rightmost digit)
load_ready  out  1  pending buffer empty; a load is accepted when load_valid && load_ready
refresh_sel  out  2  current slot: 0 = ones (right) ... 3 = thousands (left)
digit_value  out  4  active-buffer nibble for the current slot
digit_blank  out  1  1 when the current digit is suppressed by lz_en
anode_n  out  4  active-low anode enables; bit i corresponds to refresh_sel == i
frame_done  out  1  one-cycle pulse at the end of the slot where refresh_sel == 3

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler = 0; refresh_sel = 0; state = GUARD.
  - anode_n = 4'b1111; digit_value = 0; digit_blank = 0; frame_done = 0.
  - active buffer = 0; pending_full = 0.
- load_ready = !pending_full (combinational), so it reads 1 from the first cycle after reset.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while enable=1.
  - At REFRESH_DIV-1 it wraps to 0 and refresh_sel increments mod 4 (3 wraps to 0).
- FSM states:
  - GUARD while prescaler < BLANK_CYCLES; ON otherwise.
  - GUARD: anode_n = 1111.
  - ON: anode_n = ~(1 << refresh_sel), unless digit_blank = 1, in which case anode_n = 1111.
  - With BLANK_CYCLES = 0, GUARD is never entered.
- Outputs are registered. refresh_sel, digit_value and digit_blank update on the same edge that starts a new slot, so the segment path settles during GUARD.
- Load handshake:
  - An accepted load writes the pending buffer and sets pending_full.
  - load_ready does not depend on load_valid.
- Frame commit: at the last cycle of slot 3 (the frame_done cycle), if pending_full, then active <= pending and pending_full <= 0. The new digits take effect from slot 0 of the next frame.
- Simultaneous events:
  - A load accepted on the commit cycle, with pending previously empty, is captured into pending and commits at the following frame end. There is no bypass into the active buffer.
  - When pending is full on the commit cycle, load_ready is 1 on the next cycle.
- Leading-zero blanking (lz_en=1):
  - Thousands is blanked if it is 0.
  - Hundreds is blanked if it and thousands are 0.
  - Tens is blanked if it, hundreds and thousands are all 0.
  - Ones is never blanked.
  - Evaluated against the active buffer.
- Nibble values above 9 pass through unmodified; the decoder handles them.
- enable=0:
  - prescaler and refresh_sel hold.
  - anode_n = 1111 on the next edge; frame_done = 0; no commit occurs.
  - The load port still accepts while pending is empty.
- enable 0->1: resumes from the held prescaler value; the slot is not restarted.
- Reset mid-frame or with pending_full set: all state is cleared as listed above, and the pending data is discarded.

Decomposition:
- Shared package seg_pkg:
  - slot index constants SLOT_ONES=0, SLOT_TENS=1, SLOT_HUNDREDS=2, SLOT_THOUSANDS=3;
  - ANODE_OFF = 4'b1111;
  - FSM state encoding GUARD/ON.
- One natural sub-module, seg_digit_buffer: pending/active registers, pending_full flag, handshake and commit logic.
- The prescaler, FSM and blanking logic stay in the top level.

Test Plan:
- Reset with REFRESH_DIV=8, BLANK_CYCLES=2; hold rst_n=0 for 3 clk -> anode_n=1111, refresh_sel=0, load_ready=1; after release the first ON cycle is cycle 2 with anode_n=1110.
- Load 16'h1234 mid-frame -> the current frame still shows 0000; from the next slot 0, digit_value sequence is 4,3,2,1 with anode_n 1110,1101,1011,0111; each slot shows 2 GUARD cycles of 1111.
- Back-to-back loads 16'h1111 then 16'h2222 in the same frame -> the second load sees load_ready=0 until commit; the display shows 1111 for one frame, then 2222.
- Load accepted on the frame_done cycle -> captured into pending, committed one frame later, never shown in the immediately following frame.
- lz_en=1 with 16'h0045 -> thousands and hundreds blanked (anode_n=1111 in slots 3 and 2), 4 and 5 shown; with 16'h0000 only ones is lit, value 0.
- enable=0 at prescaler=5 for 10 cycles -> anode_n=1111, prescaler and refresh_sel frozen, no frame_done; after re-enable the slot completes in the remaining 2 cycles. Assert rst_n=0 mid-slot -> all registers return to their reset values on the next edge.
